// File: rtl/pc_sequencer_if.sv
// Instruction memory fetch port used by pc_sequencer.
// master: the sequencer (drives request and address).
// slave:  the instruction memory (returns the acknowledge).
interface pc_sequencer_if #(
  parameter int PC_W = 8
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;

  modport master (output mem_req, output mem_addr, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_ack);
endinterface : pc_sequencer_if

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-control FSM that owns the program counter.
// It issues a fetch at pc, waits for the memory acknowledge, then advances
// pc by a sequential step, a jump, or (optionally) a call/return.
// Optional return-address stack: define PC_SEQ_CALLSTACK_EN to build it.
// Without the macro, call/ret are ignored and stack_err is tied low.
module pc_sequencer #(
  parameter int PC_W        = 8,
  parameter int STEP        = 4,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               halt,
  pc_sequencer_if.master     mem,
  input  logic               jmp_valid,
  input  logic [PC_W-1:0]    jmp_target,
  input  logic               call,
  input  logic               ret,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_valid,
  output logic               halted,
  output logic               stack_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            mem_req_q, mem_req_d;
  logic [PC_W-1:0] mem_addr_q, mem_addr_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            halted_q, halted_d;

  // PC chosen for the ADVANCE cycle (jump, return, or sequential step).
  logic [PC_W-1:0] adv_pc;
  logic [PC_W-1:0] pc_seq;

  // Sequential step wraps naturally at 2^PC_W.
  assign pc_seq = pc_q + PC_W'(STEP);

`ifdef PC_SEQ_CALLSTACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-1:0] sp_m1;
  logic            stack_err_q, stack_err_d;
  logic            push_en;

  assign sp_m1 = sp_q - SP_W'(1);

  // Next-PC selection with call/return handling; stack only moves in ADVANCE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    adv_pc      = pc_seq;
    push_en     = 1'b0;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    if (state_q == ST_ADVANCE) begin
      if (jmp_valid) begin
        adv_pc = jmp_target;
        if (call) begin
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            stack_err_d = 1'b1;           // overflow: push dropped, jump kept
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end
      end else if (ret) begin
        if (sp_q == '0) begin
          stack_err_d = 1'b1;             // underflow: fall back to sequential
        end else begin
          adv_pc = stack_q[sp_m1[IDX_W-1:0]];
          sp_d   = sp_m1;
        end
      end
    end
  end

  // Stack pointer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Return-address storage.
  // NOTE: the stack array has no reset; entries are only read below sp_q,
  // and sp_q is reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[sp_q[IDX_W-1:0]] <= pc_seq;
    end
  end

  assign stack_err = stack_err_q;
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  logic unused_call_ret;
  assign unused_call_ret = call ^ ret;

  // Next-PC selection without a stack: call/ret have no effect.
  always_comb begin
    adv_pc = jmp_valid ? jmp_target : pc_seq;
  end

  assign stack_err = 1'b0;
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= PC_W'(RESET_PC);
      mem_req_q     <= 1'b0;
      mem_addr_q    <= PC_W'(RESET_PC);
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fetch_valid_d = 1'b0;
    halted_d      = halted_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ena && !halt) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      ST_FETCH: begin
        // Request held until acknowledged; ena is deliberately not looked at.
        if (mem.mem_ack) begin
          state_d       = ST_ADVANCE;
          mem_req_d     = 1'b0;
          fetch_valid_d = 1'b1;
        end
      end
      ST_ADVANCE: begin
        pc_d = adv_pc;
        if (halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (ena) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = adv_pc;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (!halt) begin
          state_d  = ST_IDLE;
          halted_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign pc           = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign halted       = halted_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of per-cycle vectors plus
// hand-written sequences for reset-in-flight and call/return behaviour.
module tb_pc_sequencer;

  localparam int PC_W = 8;

  logic            clk;
  logic            rst_n;
  logic            ena;
  logic            halt;
  logic            jmp_valid;
  logic [PC_W-1:0] jmp_target;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic            halted;
  logic            stack_err;

  int total;
  int bad;

  pc_sequencer_if #(.PC_W(PC_W)) mem_if ();

  pc_sequencer #(
    .PC_W(PC_W), .STEP(4), .RESET_PC(0), .STACK_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .halt       (halt),
    .mem        (mem_if.master),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .call       (call),
    .ret        (ret),
    .pc         (pc),
    .fetch_valid(fetch_valid),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            ena, halt, ack, jv;
    logic [PC_W-1:0] tgt;
    logic            cl, rt;
    logic            exp_req;
    logic [PC_W-1:0] exp_addr, exp_pc;
    logic            exp_fv, exp_halted;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic e, h, a, j, input logic [PC_W-1:0] t,
                              input logic c, r, q, input logic [PC_W-1:0] ad, p,
                              input logic fv, hl);
    vec_t v;
    v.ena = e; v.halt = h; v.ack = a; v.jv = j; v.tgt = t; v.cl = c; v.rt = r;
    v.exp_req = q; v.exp_addr = ad; v.exp_pc = p; v.exp_fv = fv; v.exp_halted = hl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic e, h, a, j, input logic [PC_W-1:0] t, input logic c, r);
    ena = e; halt = h; mem_if.mem_ack = a; jmp_valid = j; jmp_target = t; call = c; ret = r;
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 8'h00, 0, 0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // From FETCH: ack, then apply ADVANCE inputs with ena=1, landing in FETCH.
  task automatic fetch_adv(input logic j, input logic [PC_W-1:0] t, input logic c, r);
    set_in(1, 0, 1, 0, 8'h00, 0, 0);
    step();
    set_in(1, 0, 0, j, t, c, r);
    step();
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 8'h00, 0, 0);

    //             ena h ack jv tgt    c r | req addr   pc     fv hl
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0);
    vecs[1]  = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0);
    vecs[2]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h04, 8'h04, 0, 0);
    vecs[3]  = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h08, 8'h08, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h08, 8'h08, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h08, 8'h08, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h08, 8'h08, 0, 0);
    vecs[8]  = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h0C, 8'h0C, 0, 0);
    vecs[10] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h0C, 1, 0);
    vecs[11] = mk(1, 0, 0, 1, 8'h40, 0, 1, 1, 8'h40, 8'h40, 0, 0);
    vecs[12] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h40, 1, 0);
    vecs[13] = mk(1, 0, 0, 1, 8'hFC, 0, 0, 1, 8'hFC, 8'hFC, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFC, 1, 0);
    vecs[15] = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0);
    vecs[16] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0);
    vecs[17] = mk(1, 0, 1, 0, 8'h00, 0, 0, 1, 8'h04, 8'h04, 0, 0);
    vecs[18] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 1, 0);
    vecs[19] = mk(1, 0, 0, 1, 8'h10, 0, 0, 1, 8'h10, 8'h10, 0, 0);
    vecs[20] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h10, 1, 0);
    vecs[21] = mk(1, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h14, 0, 1);
    vecs[22] = mk(1, 1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h14, 0, 1);
    vecs[23] = mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h14, 0, 0);
    vecs[24] = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h14, 8'h14, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h14, 8'h14, 0, 0);
    vecs[26] = mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h14, 1, 0);
    vecs[27] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h18, 0, 0);
    vecs[28] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h18, 0, 0);
    vecs[29] = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'h18, 8'h18, 0, 0);
    vecs[30] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h18, 1, 0);
    vecs[31] = mk(1, 1, 0, 1, 8'h30, 0, 0, 0, 8'h00, 8'h30, 0, 1);
    vecs[32] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h30, 0, 0);

    // Reset state
    step();
    check("rst.req", 32'(mem_if.mem_req), 32'd0);
    check("rst.addr", 32'(mem_if.mem_addr), 32'h00);
    check("rst.pc", 32'(pc), 32'h00);
    check("rst.fv", 32'(fetch_valid), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.stack_err", 32'(stack_err), 32'd0);
    rst_n = 1'b1;

    // Table-driven run
    for (int i = 0; i < NVEC; i++) begin
      set_in(vecs[i].ena, vecs[i].halt, vecs[i].ack, vecs[i].jv, vecs[i].tgt,
             vecs[i].cl, vecs[i].rt);
      step();
      check($sformatf("vec%0d.req", i), 32'(mem_if.mem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        check($sformatf("vec%0d.addr", i), 32'(mem_if.mem_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d.pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      check($sformatf("vec%0d.fv", i), 32'(fetch_valid), 32'(vecs[i].exp_fv));
      check($sformatf("vec%0d.halted", i), 32'(halted), 32'(vecs[i].exp_halted));
      check($sformatf("vec%0d.stack_err", i), 32'(stack_err), 32'd0);
    end

    // Reset asserted mid-FETCH acts without a clock edge
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
    step();
    check("midrst.pre_req", 32'(mem_if.mem_req), 32'd1);
    check("midrst.pre_addr", 32'(mem_if.mem_addr), 32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.req", 32'(mem_if.mem_req), 32'd0);
    check("midrst.pc", 32'(pc), 32'h00);
    check("midrst.addr", 32'(mem_if.mem_addr), 32'h00);
    set_in(0, 0, 1, 0, 8'h00, 0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("midrst.no_fv%0d", i), 32'(fetch_valid), 32'd0);
      check($sformatf("midrst.idle_req%0d", i), 32'(mem_if.mem_req), 32'd0);
    end

`ifdef PC_SEQ_CALLSTACK_EN
    // Call to 0x80 from 0x10, then return to 0x14
    do_reset();
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
    step();
    fetch_adv(1, 8'h10, 0, 0);
    check("call.at10", 32'(mem_if.mem_addr), 32'h10);
    fetch_adv(1, 8'h80, 1, 0);
    check("call.addr80", 32'(mem_if.mem_addr), 32'h80);
    fetch_adv(0, 8'h00, 0, 1);
    check("ret.addr14", 32'(mem_if.mem_addr), 32'h14);
    check("ret.pc14", 32'(pc), 32'h14);
    check("ret.err", 32'(stack_err), 32'd0);

    // Five nested calls from pc 0: fifth overflows but still jumps
    do_reset();
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
    step();
    fetch_adv(1, 8'h80, 1, 0);
    check("nest1.err", 32'(stack_err), 32'd0);
    fetch_adv(1, 8'h90, 1, 0);
    check("nest2.err", 32'(stack_err), 32'd0);
    fetch_adv(1, 8'hA0, 1, 0);
    check("nest3.err", 32'(stack_err), 32'd0);
    fetch_adv(1, 8'hB0, 1, 0);
    check("nest4.err", 32'(stack_err), 32'd0);
    check("nest4.addr", 32'(mem_if.mem_addr), 32'hB0);
    fetch_adv(1, 8'hC0, 1, 0);
    check("nest5.err", 32'(stack_err), 32'd1);
    check("nest5.addr", 32'(mem_if.mem_addr), 32'hC0);
    fetch_adv(0, 8'h00, 0, 1);
    check("nest.ret_top", 32'(mem_if.mem_addr), 32'hA4);

    // Return on empty stack: sequential advance, sticky error
    do_reset();
    check("empty.err_clr", 32'(stack_err), 32'd0);
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
    step();
    fetch_adv(0, 8'h00, 0, 1);
    check("empty.addr", 32'(mem_if.mem_addr), 32'h04);
    check("empty.err", 32'(stack_err), 32'd1);
    fetch_adv(0, 8'h00, 0, 0);
    check("empty.sticky", 32'(stack_err), 32'd1);
    check("empty.next", 32'(mem_if.mem_addr), 32'h08);
`else
    // Without the stack, call+jmp is a plain jump and ret is ignored
    do_reset();
    set_in(1, 0, 0, 0, 8'h00, 0, 0);
    step();
    fetch_adv(1, 8'h80, 1, 0);
    check("nostk.call_addr", 32'(mem_if.mem_addr), 32'h80);
    fetch_adv(0, 8'h00, 0, 1);
    check("nostk.ret_addr", 32'(mem_if.mem_addr), 32'h84);
    check("nostk.ret_pc", 32'(pc), 32'h84);
    check("nostk.err", 32'(stack_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_sequencer
